// File: rtl/wm8731_pkg.sv
// Shared types and constants for the WM8731 configuration sequencer:
// FSM state encoding, register-write entry format and the fixed init table.
package wm8731_pkg;

  localparam int IDX_W  = 4;
  localparam int CNT_W  = 16;
  localparam int N_REGS = 10;

  localparam logic [6:0] R_LHPOUT = 7'h02;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_LOAD,
    ST_REQ,
    ST_WAIT_DONE,
    ST_GAP,
    ST_READY,
    ST_ERROR
  } state_t;

  typedef struct packed {
    logic [6:0] ra;
    logic [8:0] rd;
  } reg_entry_t;

  // Power-up order: reset, partial power-down, line/headphone levels,
  // path routing, interface format, then activate.
  function automatic reg_entry_t table_entry(input logic [IDX_W-1:0] idx);
    reg_entry_t e;
    case (idx)
      4'd0:    e = '{ra: 7'h0F, rd: 9'h000};
      4'd1:    e = '{ra: 7'h06, rd: 9'h010};
      4'd2:    e = '{ra: 7'h00, rd: 9'h017};
      4'd3:    e = '{ra: 7'h01, rd: 9'h017};
      4'd4:    e = '{ra: 7'h02, rd: 9'h079};
      4'd5:    e = '{ra: 7'h03, rd: 9'h079};
      4'd6:    e = '{ra: 7'h04, rd: 9'h012};
      4'd7:    e = '{ra: 7'h05, rd: 9'h000};
      4'd8:    e = '{ra: 7'h07, rd: 9'h002};
      4'd9:    e = '{ra: 7'h09, rd: 9'h001};
      default: e = '{ra: 7'h00, rd: 9'h000};
    endcase
    return e;
  endfunction

endpackage

// File: rtl/wm8731_cfg_seq.sv
// WM8731 register-init sequencer driving a 2-wire write master.
// Optional headphone volume writes from READY: define WM8731_VOL_UPDATE_EN.
module wm8731_cfg_seq
  import wm8731_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR       = 7'h1A,
  parameter int unsigned PWRUP_CYCLES   = 50000,
  parameter int unsigned GAP_CYCLES     = 64,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cfg_go,
  output logic       i2c_start,
  output logic [6:0] i2c_addr,
  output logic       i2c_wr_rd,
  output logic [7:0] i2c_data_st,
  output logic [7:0] i2c_data_nd,
  input  logic       i2c_busy,
  input  logic       i2c_done,
  output logic       cfg_busy,
  output logic       cfg_done,
  output logic       cfg_err,
  output logic [3:0] cfg_idx
`ifdef WM8731_VOL_UPDATE_EN
  ,
  input  logic       vol_req,
  input  logic [6:0] vol_val,
  output logic       vol_ack
`endif
);

  localparam logic [CNT_W-1:0] PWRUP_LAST   = CNT_W'(PWRUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(N_REGS - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             vol_mode_q, vol_mode_d;
  logic             out_en_q;
  logic             load_en;
  reg_entry_t       load_entry;
  logic [7:0]       data_st_q, data_nd_q;

  assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

  // State, index and shared counter; data bytes are captured on entry to
  // LOAD so they are stable for a full cycle before the start pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_PWRUP;
      idx_q      <= '0;
      cnt_q      <= '0;
      vol_mode_q <= 1'b0;
      out_en_q   <= 1'b0;
      data_st_q  <= '0;
      data_nd_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      vol_mode_q <= vol_mode_d;
      out_en_q   <= 1'b1;
      if (load_en) begin
        data_st_q <= {load_entry.ra, load_entry.rd[8]};
        data_nd_q <= load_entry.rd[7:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    vol_mode_d = vol_mode_q;
    load_en    = 1'b0;
    load_entry = table_entry(idx_q);
    i2c_start  = 1'b0;

    case (state_q)
      ST_PWRUP: begin
        if (cnt_q >= PWRUP_LAST) begin
          state_d    = ST_LOAD;
          idx_d      = '0;
          cnt_d      = '0;
          load_en    = 1'b1;
          load_entry = table_entry(IDX_W'(0));
        end else begin
          cnt_d = cnt_inc;
        end
      end

      ST_LOAD: begin
        state_d = ST_REQ;
        cnt_d   = '0;
      end

      // Hold the request until the master is idle so start never overlaps busy.
      ST_REQ: begin
        cnt_d = '0;
        if (!i2c_busy) begin
          i2c_start = 1'b1;
          state_d   = ST_WAIT_DONE;
        end
      end

      ST_WAIT_DONE: begin
        if (i2c_done) begin
          state_d = ST_GAP;
          cnt_d   = '0;
        end else if (cnt_q >= TIMEOUT_LAST) begin
          state_d    = ST_ERROR;
          vol_mode_d = 1'b0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      ST_GAP: begin
        if (cnt_q >= GAP_LAST) begin
          cnt_d = '0;
          if (vol_mode_q) begin
            state_d    = ST_READY;
            vol_mode_d = 1'b0;
          end else if (idx_q == LAST_IDX) begin
            state_d = ST_READY;
          end else begin
            state_d    = ST_LOAD;
            idx_d      = idx_q + 1'b1;
            load_en    = 1'b1;
            load_entry = table_entry(idx_q + 1'b1);
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end

      // A rerun request takes priority over a volume write.
      ST_READY: begin
        if (cfg_go) begin
          state_d    = ST_LOAD;
          idx_d      = '0;
          cnt_d      = '0;
          load_en    = 1'b1;
          load_entry = table_entry(IDX_W'(0));
        end
`ifdef WM8731_VOL_UPDATE_EN
        else if (vol_req) begin
          state_d    = ST_LOAD;
          cnt_d      = '0;
          vol_mode_d = 1'b1;
          load_en    = 1'b1;
          load_entry = '{ra: R_LHPOUT, rd: {1'b1, 1'b0, vol_val}};
        end
`endif
      end

      ST_ERROR: begin
        if (cfg_go) begin
          state_d    = ST_LOAD;
          idx_d      = '0;
          cnt_d      = '0;
          load_en    = 1'b1;
          load_entry = table_entry(IDX_W'(0));
        end
      end

      default: begin
        state_d = ST_PWRUP;
        cnt_d   = '0;
      end
    endcase
  end

  assign i2c_addr    = DEV_ADDR;
  assign i2c_wr_rd   = 1'b0;
  assign i2c_data_st = data_st_q;
  assign i2c_data_nd = data_nd_q;
  assign cfg_idx     = idx_q;
  assign cfg_done    = (state_q == ST_READY) || vol_mode_q;
  assign cfg_err     = (state_q == ST_ERROR);
  assign cfg_busy    = out_en_q && (state_q != ST_READY) && (state_q != ST_ERROR);

`ifdef WM8731_VOL_UPDATE_EN
  assign vol_ack = (state_q == ST_WAIT_DONE) && i2c_done && vol_mode_q;
`endif

endmodule

// File: tb/tb_wm8731_cfg_seq.sv
// Scoreboard bench for wm8731_cfg_seq: bus model with programmable done
// withholding, expected writes queued by stimulus and popped on each start.
module tb_wm8731_cfg_seq;

  localparam int PWRUP   = 200;
  localparam int GAP     = 64;
  localparam int TIMEOUT = 4096;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cfg_go = 1'b0;
  logic       i2c_start;
  logic [6:0] i2c_addr;
  logic       i2c_wr_rd;
  logic [7:0] i2c_data_st;
  logic [7:0] i2c_data_nd;
  logic       bus_busy, bus_done;
  logic       cfg_busy, cfg_done, cfg_err;
  logic [3:0] cfg_idx;
  logic       vol_req = 1'b0;
  logic [6:0] vol_val = 7'h00;
  logic       vol_ack;

  typedef struct packed {
    logic [7:0] st;
    logic [7:0] nd;
  } exp_t;

  exp_t sb_q[$];

  logic [7:0] exp_st [10] = '{8'h1E, 8'h0C, 8'h00, 8'h02, 8'h04, 8'h06, 8'h08, 8'h0A, 8'h0E, 8'h12};
  logic [7:0] exp_nd [10] = '{8'h00, 8'h10, 8'h17, 8'h17, 8'h79, 8'h79, 8'h12, 8'h00, 8'h02, 8'h01};

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int start_cnt = 0;
  int first_start_cyc = -1;
  int last_start_cyc = -1;
  int withhold_at = -1;
  int start_target = 0;
  int vol_ack_cnt = 0;
  int err_cyc = 0;
  int bus_timer = 0;
  logic bus_hold = 1'b0;
  logic prev_start = 1'b0;

  always #5 clk = ~clk;

  wm8731_cfg_seq #(
    .DEV_ADDR(7'h1A),
    .PWRUP_CYCLES(PWRUP),
    .GAP_CYCLES(GAP),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .cfg_go(cfg_go),
    .i2c_start(i2c_start),
    .i2c_addr(i2c_addr),
    .i2c_wr_rd(i2c_wr_rd),
    .i2c_data_st(i2c_data_st),
    .i2c_data_nd(i2c_data_nd),
    .i2c_busy(bus_busy),
    .i2c_done(bus_done),
    .cfg_busy(cfg_busy),
    .cfg_done(cfg_done),
    .cfg_err(cfg_err),
    .cfg_idx(cfg_idx)
`ifdef WM8731_VOL_UPDATE_EN
    ,
    .vol_req(vol_req),
    .vol_val(vol_val),
    .vol_ack(vol_ack)
`endif
  );

`ifndef WM8731_VOL_UPDATE_EN
  assign vol_ack = 1'b0;
`endif

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  // Master model: busy for 40 cycles after each start, then a done pulse
  // unless this start is the one selected for withholding.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus_busy  <= 1'b0;
      bus_done  <= 1'b0;
      bus_timer <= 0;
      bus_hold  <= 1'b0;
    end else begin
      bus_done <= 1'b0;
      if (i2c_start) begin
        bus_busy  <= 1'b1;
        bus_timer <= 1;
        bus_hold  <= (start_cnt == withhold_at);
      end else if (bus_busy) begin
        if (bus_timer == 40) begin
          bus_busy <= 1'b0;
          bus_done <= !bus_hold;
        end else begin
          bus_timer <= bus_timer + 1;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every start pops one expected write and checks its framing.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_start      = 1'b0;
        first_start_cyc = -1;
        last_start_cyc  = -1;
      end else begin
        if (vol_ack) vol_ack_cnt++;
        if (i2c_start) begin
          start_cnt++;
          if (first_start_cyc < 0) first_start_cyc = cyc;
          checkOutput("start_width", {31'd0, prev_start}, 32'd0);
          checkOutput("start_vs_busy", {31'd0, bus_busy}, 32'd0);
          if (last_start_cyc >= 0)
            checkOutput("start_spacing", 32'(cyc - last_start_cyc >= GAP), 32'd1);
          last_start_cyc = cyc;
          if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL unexpected_start: actual=start required=none at cycle %0d", cyc);
          end else begin
            e = sb_q.pop_front();
            checkOutput("data_st", {24'd0, i2c_data_st}, {24'd0, e.st});
            checkOutput("data_nd", {24'd0, i2c_data_nd}, {24'd0, e.nd});
            checkOutput("addr", {25'd0, i2c_addr}, 32'h1A);
            checkOutput("wr_rd", {31'd0, i2c_wr_rd}, 32'd0);
          end
        end
        prev_start = i2c_start;
      end
    end
  end

  task automatic pushExpected(input int first, input int last);
    for (int i = first; i <= last; i++) sb_q.push_back('{st: exp_st[i], nd: exp_nd[i]});
  endtask

  task automatic applyStimulus(input int first, input int last);
    pushExpected(first, last);
    @(negedge clk);
    cfg_go = 1'b1;
    @(negedge clk);
    cfg_go = 1'b0;
  endtask

  // sel: 0 cfg_done, 1 cfg_err, 2 vol_ack seen, 3 start count reached target
  task automatic waitSignal(input string name, input int sel, input int budget);
    int n = 0;
    while (n < budget) begin
      @(negedge clk);
      if ((sel == 0 && cfg_done) || (sel == 1 && cfg_err) ||
          (sel == 2 && vol_ack_cnt > 0) || (sel == 3 && start_cnt >= start_target)) break;
      n++;
    end
    checkOutput(name, 32'(n < budget), 32'd1);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_start", {31'd0, i2c_start}, 32'd0);
    checkOutput("rst_addr", {25'd0, i2c_addr}, 32'h1A);
    checkOutput("rst_busy", {31'd0, cfg_busy}, 32'd0);
    checkOutput("rst_done", {31'd0, cfg_done}, 32'd0);
    checkOutput("rst_err", {31'd0, cfg_err}, 32'd0);
    checkOutput("rst_idx", {28'd0, cfg_idx}, 32'd0);
    checkOutput("rst_data", {16'd0, i2c_data_st, i2c_data_nd}, 32'd0);

    // Power-up and full table
    pushExpected(0, 9);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("pwrup_busy", {31'd0, cfg_busy}, 32'd1);
    waitSignal("run1_done_in_time", 0, 6000);
    checkOutput("run1_first_start_cycle", 32'(first_start_cyc), 32'(PWRUP + 1));
    checkOutput("run1_start_count", 32'(start_cnt), 32'd10);
    checkOutput("run1_idx", {28'd0, cfg_idx}, 32'd9);
    checkOutput("run1_busy", {31'd0, cfg_busy}, 32'd0);
    checkOutput("run1_err", {31'd0, cfg_err}, 32'd0);

    // Withhold done on entry 3 -> timeout
    withhold_at = start_cnt + 4;
    applyStimulus(0, 3);
    waitSignal("timeout_err_in_time", 1, 8000);
    err_cyc = cyc;
    checkOutput("timeout_latency", 32'(err_cyc - last_start_cyc), 32'(TIMEOUT + 1));
    checkOutput("timeout_done", {31'd0, cfg_done}, 32'd0);
    checkOutput("timeout_busy", {31'd0, cfg_busy}, 32'd0);
    checkOutput("timeout_idx", {28'd0, cfg_idx}, 32'd3);
    repeat (300) @(negedge clk);
    checkOutput("error_no_starts", 32'(start_cnt), 32'd14);
    checkOutput("error_err_sticky", {31'd0, cfg_err}, 32'd1);

    // Rerun from ERROR
    withhold_at = -1;
    applyStimulus(0, 9);
    @(negedge clk);
    checkOutput("rerun_err_clear", {31'd0, cfg_err}, 32'd0);
    checkOutput("rerun_busy", {31'd0, cfg_busy}, 32'd1);
    waitSignal("rerun_done_in_time", 0, 6000);
    checkOutput("rerun_idx", {28'd0, cfg_idx}, 32'd9);
    checkOutput("rerun_start_count", 32'(start_cnt), 32'd24);

    // Reset during entry 5 WAIT_DONE
    start_target = start_cnt + 6;
    applyStimulus(0, 5);
    waitSignal("entry5_start_in_time", 3, 3000);
    repeat (10) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_rst_start", {31'd0, i2c_start}, 32'd0);
    checkOutput("async_rst_busy", {31'd0, cfg_busy}, 32'd0);
    checkOutput("async_rst_idx", {28'd0, cfg_idx}, 32'd0);
    checkOutput("async_rst_data", {16'd0, i2c_data_st, i2c_data_nd}, 32'd0);
    checkOutput("async_rst_sb_empty", 32'(sb_q.size()), 32'd0);
    repeat (3) @(negedge clk);
    pushExpected(0, 9);
    reset_n = 1'b1;
    waitSignal("post_rst_done_in_time", 0, 6000);
    checkOutput("post_rst_first_start_cycle", 32'(first_start_cyc), 32'(PWRUP + 1));
    checkOutput("post_rst_idx", {28'd0, cfg_idx}, 32'd9);

`ifdef WM8731_VOL_UPDATE_EN
    // Volume write: R2 with LRHPBOTH=1, LZCEN=0, code 0x60
    sb_q.push_back('{st: 8'h05, nd: 8'h60});
    @(negedge clk);
    vol_val = 7'h60;
    vol_req = 1'b1;
    @(negedge clk);
    vol_req = 1'b0;
    vol_val = 7'h00;
    checkOutput("vol_done_held", {31'd0, cfg_done}, 32'd1);
    waitSignal("vol_ack_in_time", 2, 500);
    repeat (100) @(negedge clk);
    checkOutput("vol_ack_count", 32'(vol_ack_cnt), 32'd1);
    checkOutput("vol_ready_done", {31'd0, cfg_done}, 32'd1);
`endif

    repeat (5) @(negedge clk);
    checkOutput("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
